dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 256, shall give the data memory size in bytes; legal word addresses are 0..MEM_BYTES-4.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req0/req1  in  1 each  access request from port 0 (CPU) / port 1 (loader).
REQ-005 we0/we1  in  1 each  1 = write, 0 = read; held stable with req.
REQ-006 addr0/addr1  in  32 each  byte address; held stable with req.
REQ-007 wdata0/wdata1  in  32 each  write data, big-endian (bits 31:24 at lowest byte); held stable with req.
REQ-008 ack0/ack1  out  1 each  one-cycle completion pulse.
REQ-009 err0/err1  out  1 each  valid with ack; 1 = access rejected.
REQ-010 rdata0/rdata1  out  32 each  read data, valid in the ack cycle.
REQ-011 mem_en_write  out  1  write enable to data memory; memory writes on falling clk edge.
REQ-012 mem_address  out  32  byte address to memory.
REQ-013 mem_data_i  out  32  write data to memory.
REQ-014 mem_data_o  in  32  combinational read data from memory.

Function
REQ-015 FSM states: IDLE, SERVE, RESP; IDLE->SERVE when any unmasked req; SERVE->RESP always; RESP->IDLE always.
REQ-016 In IDLE, both req high: grant the port not granted last (round-robin pointer); after reset, pointer favours port 0.
REQ-017 On IDLE->SERVE edge: latch winner index, we, addr, wdata; update round-robin pointer to winner.
REQ-018 In SERVE: mem_address = latched addr; mem_data_i = latched wdata; mem_en_write = latched we AND NOT err AND NOT rst.
REQ-019 Outside SERVE: mem_en_write = 0; mem_address and mem_data_i = 0.
REQ-020 err set when addr[1:0] != 0 or addr > MEM_BYTES-4; errored access shall not write memory and shall return rdata 0.
REQ-021 On SERVE->RESP edge: winner's rdata <= mem_data_o for legal reads, 0 for writes or errors; winner's ack and err registered.
REQ-022 ack/err high only in RESP, only for the winner, exactly one cycle per grant.
REQ-023 rdataN holds its value until that port's next RESP.
REQ-024 Port acked in RESP is masked from arbitration in the following IDLE cycle (stale req guard); requester drops req or presents a new request after ack.
REQ-025 Latency: req sampled high in IDLE -> ack exactly 2 cycles later; throughput one access per 3 cycles.
REQ-026 Req changes during SERVE/RESP do not affect the access in progress.

Reset
REQ-027 rst high at a rising edge: state IDLE, pointer favours port 0, ack0/1 = 0, err0/1 = 0, rdata0/1 = 0, latched fields = 0.
REQ-028 rst asserted during SERVE: access abandoned, no ack issued, mem_en_write forced 0 combinationally so the falling-edge write is suppressed.

Structure
REQ-029 Shared package holds FSM state encoding (2 bits), port index constants, MEM_BYTES default.
REQ-030 Single sub-module rr_arb2 (two-way round-robin arbiter: req vector, mask, pointer -> one-hot grant); remainder flat.

Verification
REQ-031 req0, we0=1, addr0=0x10, wdata0=0xDEADBEEF; then read 0x10 -> bytes 0x10..0x13 = DE AD BE EF, ack0 two cycles after req, rdata0=0xDEADBEEF, err0=0.
REQ-032 req0 and req1 both held continuously -> grants alternate 0,1,0,1; each ack every 3 cycles; first grant after reset to port 0.
REQ-033 req1 write addr1=0x11, then addr1=MEM_BYTES-2 -> ack1 with err1=1 each time, mem_en_write never 1, memory unchanged.
REQ-034 Write addr 0xFC (MEM_BYTES=256) -> legal, err=0, bytes 0xFC..0xFF written.
REQ-035 rst pulsed during SERVE of a write to 0x20 -> no ack, memory 0x20..0x23 unchanged, outputs at reset values next cycle.
REQ-036 Port 0 keeps req high one cycle after ack0 while req1 high -> port 1 granted next, no duplicate port 0 access.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// port indices, default memory size and the address legality check.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int MEM_BYTES_DEF = 256;

  // Word accesses must be aligned and must fit entirely inside the memory.
  function automatic logic addr_illegal(input logic [31:0] addr,
                                        input logic [31:0] last_word);
    return (addr[1:0] != 2'b00) || (addr > last_word);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: masked request vector plus last-winner
// pointer in, one-hot grant out.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  output logic [1:0] grant
);

  logic [1:0] eligible;

  assign eligible = req & ~mask;

  // On contention, the port that did not win last time goes first.
  always_comb begin
    grant = eligible;
    if (eligible == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU (port 0) and loader (port 1) word accesses onto a single
// data memory that writes on the falling clock edge and reads combinationally.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_en_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_i,
  input  logic [31:0] mem_data_o
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_t      state;
  state_t      state_nxt;
  logic        last;
  logic [1:0]  mask;
  logic [1:0]  grant;
  logic        win;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err;
  logic [31:0] rd_val;

  rr_arb2 u_arb (
    .req   ({req1, req0}),
    .mask  (mask),
    .last  (last),
    .grant (grant)
  );

  assign err    = addr_illegal(addr_q, LAST_WORD);
  assign rd_val = (we_q || err) ? 32'd0 : mem_data_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|grant) state_nxt = ST_SERVE;
      ST_SERVE: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // rst gates the write strobe directly so a reset during SERVE also
  // suppresses the falling-edge write of that same cycle.
  always_comb begin
    mem_en_write = 1'b0;
    mem_address  = 32'd0;
    mem_data_i   = 32'd0;
    if (state == ST_SERVE) begin
      mem_en_write = we_q & ~err & ~rst;
      mem_address  = addr_q;
      mem_data_i   = wdata_q;
    end
  end

  // Request capture; last resets to PORT1 so the first contention favours port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      win     <= PORT0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      last    <= PORT1;
      mask    <= 2'b00;
    end else begin
      mask <= 2'b00;
      if (state == ST_IDLE && (|grant)) begin
        win     <= grant[PORT1] ? PORT1 : PORT0;
        we_q    <= grant[PORT1] ? we1 : we0;
        addr_q  <= grant[PORT1] ? addr1 : addr0;
        wdata_q <= grant[PORT1] ? wdata1 : wdata0;
        last    <= grant[PORT1] ? PORT1 : PORT0;
      end
      // The port being acked now may still show its old req next cycle.
      if (state == ST_RESP) begin
        mask <= (win == PORT1) ? 2'b10 : 2'b01;
      end
    end
  end

  // Response registers, loaded on the SERVE->RESP edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      rdata0 <= 32'd0;
      rdata1 <= 32'd0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      if (state == ST_SERVE) begin
        if (win == PORT1) begin
          ack1   <= 1'b1;
          err1   <= err;
          rdata1 <= rd_val;
        end else begin
          ack0   <= 1'b1;
          err0   <= err;
          rdata0 <= rd_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table of single accesses plus
// hand sequences for contention, reset during SERVE and the stale-req guard.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_en_write;
  logic [31:0] mem_address, mem_data_i, mem_data_o;

  int checks;
  int failures;

  dmem_arbiter #(.MEM_BYTES(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .req1         (req1),
    .we0          (we0),
    .we1          (we1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .ack0         (ack0),
    .ack1         (ack1),
    .err0         (err0),
    .err1         (err1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .mem_en_write (mem_en_write),
    .mem_address  (mem_address),
    .mem_data_i   (mem_data_i),
    .mem_data_o   (mem_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide big-endian memory: combinational read, falling-edge write.
  logic [7:0] mem [0:255];
  logic       mem_init;
  int         wcount;
  logic [7:0] ma;

  assign ma         = mem_address[7:0];
  assign mem_data_o = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};

  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      wcount <= 0;
    end else if (mem_en_write) begin
      mem[ma]        <= mem_data_i[31:24];
      mem[ma + 8'd1] <= mem_data_i[23:16];
      mem[ma + 8'd2] <= mem_data_i[15:8];
      mem[ma + 8'd3] <= mem_data_i[7:0];
      wcount         <= wcount + 1;
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic present(input vec_t v);
    if (v.port) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
  endtask

  // Returns in the ack cycle (or after the budget) with req still high.
  task automatic access(input vec_t v, output int lat);
    logic got;
    present(v);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (v.port ? ack1 : ack0) got = 1'b1;
    end
    if (!got) lat = 99;
  endtask

  int          lat;
  int          wc0;
  logic [31:0] exp_rd [2];
  logic        seen;
  vec_t        v;

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h11, 32'hCAFEF00D, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'hFE, 32'hCAFEF00D, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 32'hFC, 32'h12345678, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'hFC, 32'h0,        1'b0, 32'h12345678};
    vecs[6] = '{1'b1, 1'b0, 32'h03, 32'h0,        1'b1, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 32'h100, 32'h0,       1'b1, 32'h0};
    vecs[8] = '{1'b1, 1'b1, 32'h40, 32'hA5A50F0F, 1'b0, 32'h0};
    vecs[9] = '{1'b0, 1'b0, 32'h40, 32'h0,        1'b0, 32'hA5A50F0F};

    rst = 1'b1; mem_init = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack_err", {28'd0, ack1, ack0, err1, err0}, 32'd0);
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_rdata1", rdata1, 32'd0);
    chk("reset_mem_en_write", {31'd0, mem_en_write}, 32'd0);
    chk("reset_mem_address", mem_address, 32'd0);
    rst = 1'b0; mem_init = 1'b0;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;

    for (int k = 0; k < NV; k++) begin
      v   = vecs[k];
      wc0 = wcount;
      access(v, lat);
      chk($sformatf("v%0d_latency", k), lat, 32'd2);
      chk($sformatf("v%0d_err", k), {31'd0, v.port ? err1 : err0}, {31'd0, v.err});
      chk($sformatf("v%0d_rdata", k), v.port ? rdata1 : rdata0, v.rdata);
      chk($sformatf("v%0d_other_ack", k), {31'd0, v.port ? ack0 : ack1}, 32'd0);
      chk($sformatf("v%0d_other_rdata_hold", k), v.port ? rdata0 : rdata1, exp_rd[!v.port]);
      exp_rd[v.port] = v.rdata;
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_mem_writes", k), wcount - wc0, (v.we && !v.err) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    chk("mem_word_10", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hDEADBEEF);
    chk("mem_word_fc", {mem[8'hFC], mem[8'hFD], mem[8'hFE], mem[8'hFF]}, 32'h12345678);
    chk("mem_word_40", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'hA5A50F0F);

    // Continuous contention right after reset: port 0 first, then strict alternation.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h40;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      chk($sformatf("alt_c%0d_acks", c), {30'd0, ack1, ack0},
          {30'd0, (c % 6) == 5, (c % 6) == 2});
      if (ack0) chk($sformatf("alt_c%0d_rdata0", c), rdata0, 32'hDEADBEEF);
      if (ack1) chk($sformatf("alt_c%0d_rdata1", c), rdata1, 32'hA5A50F0F);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset lands during SERVE of a write to 0x20.
    wc0 = wcount;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h11223344;
    @(posedge clk); #1;
    chk("rst_serve_address", mem_address, 32'h20);
    rst = 1'b1;
    #1;
    chk("rst_serve_we_forced", {31'd0, mem_en_write}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req0 = 1'b0; we0 = 1'b0;
    chk("rst_serve_acks", {28'd0, ack1, ack0, err1, err0}, 32'd0);
    chk("rst_serve_rdata0", rdata0, 32'd0);
    chk("rst_serve_rdata1", rdata1, 32'd0);
    chk("rst_serve_mem_address", mem_address, 32'd0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack0 || ack1) seen = 1'b1;
    end
    chk("rst_serve_no_ack", {31'd0, seen}, 32'd0);
    chk("rst_serve_mem_20", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'h20212223);
    chk("rst_serve_no_write", wcount - wc0, 32'd0);

    // Port 0 alone leaves req high through the IDLE cycle after its ack.
    v = '{1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF};
    access(v, lat);
    chk("stale_a_latency", lat, 32'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("stale_a_not_served", mem_address, 32'd0);
    req0 = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack0) seen = 1'b1;
    end
    chk("stale_a_no_dup_ack", {31'd0, seen}, 32'd0);

    // Same stale req with port 1 waiting: port 1 is served, port 0 is not repeated.
    access(v, lat);
    chk("stale_b_latency", lat, 32'd2);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h40;
    for (int e = 3; e <= 8; e++) begin
      @(posedge clk); #1;
      chk($sformatf("stale_b_e%0d_acks", e), {30'd0, ack1, ack0}, {30'd0, e == 5, 1'b0});
      if (e == 4) req0 = 1'b0;
      if (e == 5) req1 = 1'b0;
    end
    chk("stale_b_rdata1", rdata1, 32'hA5A50F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
